// File: rtl/mux_8bits_arbiter.sv
// Two-source round-robin arbiter driving a shared 2:1 mux into a registered valid/ready stage.
// Latency: 1 cycle request-to-grant from IDLE, 1 cycle grant-to-out_data.
// Backpressure: out_valid && !out_ready holds the output register and suppresses all grants.
module mux_8bits_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src
);

  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          prio, prio_nxt;
  logic          can_accept;
  logic          last_beat;

  // The output register can take a new beat when empty or being drained this cycle.
  assign can_accept = !out_valid || out_ready;
  assign sel        = (state == GRANT_B);
  assign gnt_a      = (state == GRANT_A) && req_a && can_accept;
  assign gnt_b      = (state == GRANT_B) && req_b && can_accept;
  // A grant in this cycle would complete the owner's burst allowance.
  assign last_beat  = (count == CW'(BURST_MAX - 1));

  // Next-state, burst counter and priority decisions.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    prio_nxt  = prio;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !prio)) begin
          state_nxt = GRANT_A;
        end else if (req_b) begin
          state_nxt = GRANT_B;
        end
      end
      GRANT_A: begin
        if (!req_a) begin
          // Owner released early: hand straight to B if it is waiting.
          state_nxt = req_b ? GRANT_B : IDLE;
          count_nxt = '0;
          prio_nxt  = 1'b1;
        end else if (gnt_a) begin
          if (last_beat) begin
            count_nxt = '0;
            if (req_b) begin
              state_nxt = GRANT_B;
              prio_nxt  = 1'b1;
            end
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      GRANT_B: begin
        if (!req_b) begin
          state_nxt = req_a ? GRANT_A : IDLE;
          count_nxt = '0;
          prio_nxt  = 1'b0;
        end else if (gnt_b) begin
          if (last_beat) begin
            count_nxt = '0;
            if (req_a) begin
              state_nxt = GRANT_A;
              prio_nxt  = 1'b0;
            end
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      prio  <= prio_nxt;
    end
  end

  // Output stage: capture the granted mux result, clear valid once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (gnt_a || gnt_b) begin
      out_valid <= 1'b1;
      out_data  <= sel ? data_b : data_a;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_8bits_arbiter.sv
// Bench for mux_8bits_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a tenure/priority reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_mux_8bits_arbiter;
  localparam int WIDTH = 8;
  localparam int BM    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [WIDTH-1:0] data_a, data_b;
  logic             gnt_a, gnt_b, sel;
  logic             out_valid, out_ready, out_src;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  mux_8bits_arbiter #(.WIDTH(WIDTH), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .data_a(data_a),
    .req_b(req_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the mux (0 none, 1 A, 2 B), beats taken in this
  // tenure, which source wins a tie, and the contents of the output register.
  int         m_owner, m_taken, m_prio;
  logic       m_ov, m_osrc;
  logic [7:0] m_od;
  logic       e_ga, e_gb;

  // Observations from the most recent step, for directed checks.
  logic       obs_ga, obs_gb, obs_sel, obs_ov;
  logic [7:0] obs_dat;
  logic [7:0] log_dat[$];
  logic       log_src[$];

  logic [7:0] sv[9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
  int         idx, ncyc, nb;
  logic       pa, pb, rdy;
  logic [7:0] da_r, db_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_taken = 0; m_prio = 0;
    m_ov = 1'b0; m_od = 8'h00; m_osrc = 1'b0;
    log_dat.delete(); log_src.delete();
  endtask

  // One clock cycle: apply inputs, compare outputs to the model, advance the model.
  task automatic step(input logic ra, input logic [7:0] da, input logic rb,
                      input logic [7:0] db, input logic rd);
    logic can, own, oth;
    int   other;
    req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rd;
    #1;
    can  = !m_ov || rd;
    e_ga = (m_owner == 1) && ra && can;
    e_gb = (m_owner == 2) && rb && can;
    chk("gnt_a", gnt_a, e_ga);
    chk("gnt_b", gnt_b, e_gb);
    chk("sel", sel, m_owner == 2);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("out_src", out_src, m_osrc);
    obs_ga = gnt_a; obs_gb = gnt_b; obs_sel = sel; obs_ov = out_valid; obs_dat = out_data;
    if (out_valid && rd) begin
      log_dat.push_back(out_data);
      log_src.push_back(out_src);
    end
    @(posedge clk);
    #1;
    if (e_ga || e_gb) begin
      m_od = e_ga ? da : db; m_osrc = e_gb; m_ov = 1'b1;
    end else if (m_ov && rd) begin
      m_ov = 1'b0;
    end
    if (m_owner == 0) begin
      if (ra && (!rb || m_prio == 0)) m_owner = 1;
      else if (rb) m_owner = 2;
    end else begin
      own   = (m_owner == 1) ? ra : rb;
      oth   = (m_owner == 1) ? rb : ra;
      other = 3 - m_owner;
      if (!own) begin
        m_prio = (m_owner == 1) ? 1 : 0;
        m_owner = oth ? other : 0;
        m_taken = 0;
      end else if (e_ga || e_gb) begin
        m_taken++;
        if (m_taken == BM) begin
          m_taken = 0;
          if (oth) begin
            m_prio = (m_owner == 1) ? 1 : 0;
            m_owner = other;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; req_a = 0; req_b = 0; data_a = 0; data_b = 0; out_ready = 1;
    model_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel", sel, 0);
    chk("rst_gnt", {gnt_a, gnt_b}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single source: nine beats, one idle arbitration cycle then back-to-back grants.
    idx = 0; ncyc = 0;
    for (int c = 0; c < 30 && idx < 9; c++) begin
      step(1'b1, sv[idx], 1'b0, 8'h00, 1'b1);
      if (e_ga) idx++;
      ncyc++;
    end
    chk("single_done", idx, 9);
    chk("single_cycles", ncyc, 10);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("single_log_n", log_dat.size(), 9);
    for (int i = 0; i < 9 && i < log_dat.size(); i++) begin
      chk("single_data", log_dat[i], sv[i]);
      chk("single_src", log_src[i], 0);
    end

    // Round robin with both requesting: AA x4, 55 x4, ... with no bubble.
    do_reset();
    for (int c = 0; c < 26; c++) step(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
    chk("rr_log_n", log_dat.size() >= 24, 1);
    for (int i = 0; i < 24 && i < log_dat.size(); i++) begin
      chk("rr_data", log_dat[i], ((i / 4) % 2 == 0) ? 8'hAA : 8'h55);
      chk("rr_src", log_src[i], (i / 4) % 2);
    end

    // After A leaves, a simultaneous request from IDLE goes to B.
    do_reset();
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h22, 1'b1, 8'h33, 1'b1);
    step(1'b1, 8'h22, 1'b1, 8'h33, 1'b1);
    chk("simul_b_first", {obs_ga, obs_gb, obs_sel}, 3'b011);

    // Backpressure: hold 12 for three cycles, grant resumes in the ready cycle.
    do_reset();
    step(1'b1, 8'h12, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h12, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 8'h34, 1'b0, 8'h00, 1'b0);
      chk("bp_hold_data", obs_dat, 8'h12);
      chk("bp_no_gnt", obs_ga, 0);
    end
    step(1'b1, 8'h34, 1'b0, 8'h00, 1'b1);
    chk("bp_resume_gnt", obs_ga, 1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("bp_resume_data", {obs_ov, obs_dat}, {1'b1, 8'h34});

    // Early release: A drops after two beats, B takes over and gets a full burst.
    do_reset();
    step(1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1);
    step(1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1);
    step(1'b1, 8'hA2, 1'b1, 8'hB0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'hB0, 1'b1);
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 8'hA3, 1'b1, 8'hB0 + 8'(c), 1'b1);
      if (obs_sel && obs_gb) nb++;
    end
    chk("early_b_beats", nb, 4);
    step(1'b1, 8'hA3, 1'b1, 8'hB9, 1'b1);
    chk("early_back_to_a", {obs_sel, obs_ga}, 2'b01);

    // Asynchronous reset while B owns the mux and a beat is held.
    step(1'b0, 8'h00, 1'b1, 8'hB9, 1'b1);
    step(1'b0, 8'h00, 1'b1, 8'hB9, 1'b1);
    req_b = 1'b1; data_b = 8'hBA; out_ready = 1'b0;
    #1;
    chk("pre_rst_state", {out_valid, sel}, 2'b11);
    rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_sel", sel, 0);
    chk("async_gnt", {gnt_a, gnt_b}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Randomized traffic obeying the hold-until-grant rule, with random drops and stalls.
    pa = 0; pb = 0; da_r = 0; db_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin pa = 1; da_r = 8'($urandom); end
      if (!pb && $urandom_range(0, 3) != 0) begin pb = 1; db_r = 8'($urandom); end
      if (pa && $urandom_range(0, 31) == 0) pa = 0;
      if (pb && $urandom_range(0, 31) == 0) pb = 0;
      rdy = ($urandom_range(0, 3) != 0);
      step(pa, da_r, pb, db_r, rdy);
      if (e_ga) pa = 0;
      if (e_gb) pb = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_8bits_arbiter.md
Name: mux_8bits_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8-bit 2:1 mux datapath (a/b/sel/f).
- Decides which source drives the mux, drives `sel`, and holds a grant for bursts of up to BURST_MAX beats.
- Registers the mux result into a valid/ready output stage with backpressure.
- Sits between two 8-bit producers and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of both sources and the output.
- BURST_MAX, 4, maximum consecutive beats granted to one source while the other is requesting (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_a  input  1  source A has a beat available on data_a.
- data_a  input  WIDTH  source A data (mux input a).
- req_b  input  1  source B has a beat available on data_b.
- data_b  input  WIDTH  source B data (mux input b).
- gnt_a  output  1  beat from A accepted this cycle (combinational).
- gnt_b  output  1  beat from B accepted this cycle (combinational).
- sel  output  1  mux select; 0 = a, 1 = b; equals state==GRANT_B.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_data  output  WIDTH  registered mux result.
- out_src  output  1  source of out_data; 0 = A, 1 = B.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, beat count=0, prio=0 (A favoured).
  - out_valid=0, out_data=0, out_src=0, sel=0, gnt_a=gnt_b=0.
- Reset asserted mid-burst discards any beat held in the output register and aborts the burst.
- State machine IDLE / GRANT_A / GRANT_B. All transitions happen on the clk rising edge.
- IDLE:
  - Grants nothing.
  - req_a only -> GRANT_A.
  - req_b only -> GRANT_B.
  - Both -> GRANT_A if prio=0, else GRANT_B.
  - Neither -> stay in IDLE.
  - Arbitration latency is 1 cycle from request to first possible grant.
- can_accept = !out_valid || out_ready. This gives full-throughput pass-through when the consumer is ready.
- gnt_a = (state==GRANT_A) && req_a && can_accept. gnt_b is symmetric.
- On a grant:
  - out_data <= selected data, out_src <= sel, out_valid <= 1, count <= count+1.
  - Output latency: a beat granted in cycle N is visible on out_data in cycle N+1.
- When out_valid && out_ready and there is no new grant, out_valid <= 0.
- Under backpressure (out_valid && !out_ready), out_data, out_src and out_valid hold and no grant is issued.
- GRANT_A exit rules (GRANT_B is mirror-image):
  - !req_a: -> GRANT_B if req_b, else IDLE. count <= 0, prio <= 1.
  - A grant that brings count to BURST_MAX with req_b high: -> GRANT_B, count <= 0, prio <= 1.
  - A grant that brings count to BURST_MAX with req_b low: stay in GRANT_A, count <= 0.
- Each switch hands off directly, with no idle cycle. The first beat of the new owner can be granted in the cycle after the switch.
- A source must hold req_x and data_x stable until gnt_x. Deasserting req_x without a grant is legal and ends that source's tenure.
- Count width is clog2(BURST_MAX+1). The count never exceeds BURST_MAX.
- sel changes only on state transitions. It never toggles during a beat transfer.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-operation with out_valid=1.
  - Required: out_valid=0, out_data=8'h00, sel=0 immediately without a clock.
  - Then, with no requests for 5 cycles: gnt_a=gnt_b=0 and state stays IDLE.
- Single source:
  - Stimulus: req_a=1 with data_a=8'h01, 02, 04 … 80, 8'hFF (one per grant); out_ready=1; req_b=0.
  - Required: 9 consecutive gnt_a after 1 idle cycle.
  - Required: out_data reproduces the sequence with 1-cycle latency, out_src=0, sel=0 throughout, and count wraps without a switch.
- Round-robin fairness:
  - Stimulus: req_a=req_b=1 continuously, BURST_MAX=4, data_a=8'hAA, data_b=8'h55.
  - Required: output pattern AA×4, 55×4, AA×4 …, and sel toggles every 4 beats with no bubble.
- Simultaneous first request:
  - Stimulus: both requests rise together from IDLE after reset.
  - Required: A is served first (prio=0).
  - After A drops and later both rise again from IDLE, B is served first.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1 (out_data=8'h12).
  - Required: out_data is held at 8'h12 and gnt_a=0.
  - After out_ready returns to 1: the next beat is granted in the same cycle and appears the following cycle.
- Early release:
  - Stimulus: A deasserts req_a after 2 beats while req_b=1.
  - Required: the next cycle is GRANT_B (sel=1), B gets up to 4 beats, and count restarts from 0.
